// File: rtl/cmp_pipe.sv
// rtl/cmp_pipe.sv - pipelined branch/set-condition comparator with valid/ready handshake and flush
module cmp_pipe #(
    parameter int WIDTH = 32,
    parameter int LAT   = 2,
    parameter int TAGW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAGW-1:0]  tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             cmp,
    output logic [TAGW-1:0]  out_tag
);

    logic [WIDTH:0]  diff;
    logic            eq;
    logic            ovf;
    logic            lt;
    logic            ltu;
    logic            a_neg;
    logic            a_zero;
    logic            res;
    logic            adv;

    logic [LAT-1:0]  v_q;
    logic [LAT-1:0]  c_q;
    logic [TAGW-1:0] t_q [LAT];

    // One subtractor serves equality, signed and unsigned ordering.
    always_comb begin
        diff   = {1'b0, a} - {1'b0, b};
        eq     = ~|diff[WIDTH-1:0];
        ltu    = diff[WIDTH];
        ovf    = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);
        lt     = diff[WIDTH-1] ^ ovf;
        a_neg  = a[WIDTH-1];
        a_zero = (a == '0);
        res    = 1'b0;
        case (op)
            3'b000:  res = ~eq;
            3'b001:  res = eq;
            3'b010:  res = lt;
            3'b011:  res = ltu;
            3'b100:  res = ~a_neg;
            3'b101:  res = a_neg;
            3'b110:  res = a_neg | a_zero;
            3'b111:  res = ~a_neg & ~a_zero;
            default: res = 1'b0;
        endcase
    end

    // The whole pipe moves together; bubbles are only squeezed out at the tail.
    assign adv      = out_ready | ~v_q[LAT-1];
    assign in_ready = adv;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q <= '0;
            c_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                t_q[i] <= '0;
            end
        end else begin
            if (adv) begin
                v_q[0] <= in_valid;
                c_q[0] <= res;
                t_q[0] <= tag;
                for (int i = 1; i < LAT; i++) begin
                    v_q[i] <= v_q[i-1];
                    c_q[i] <= c_q[i-1];
                    t_q[i] <= t_q[i-1];
                end
            end
            // Flush overrides both shift and stall; data bits are left stale.
            if (flush) begin
                v_q <= '0;
            end
        end
    end

    assign out_valid = v_q[LAT-1];
    assign cmp       = c_q[LAT-1];
    assign out_tag   = t_q[LAT-1];

endmodule

// File: tb/tb_cmp_pipe.sv
// tb/tb_cmp_pipe.sv - scoreboard and vector-table bench for cmp_pipe (32/2/5 and 8/1/3 builds)
module tb_cmp_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, flush, out_valid, out_ready, cmp;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  tag, out_tag;

    logic        in_valid8, in_ready8, out_valid8, cmp8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic [2:0]  tag8, out_tag8;

    cmp_pipe #(.WIDTH(32), .LAT(2), .TAGW(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .tag(tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .cmp(cmp), .out_tag(out_tag)
    );

    cmp_pipe #(.WIDTH(8), .LAT(1), .TAGW(3)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .a(a8), .b(b8), .tag(tag8), .flush(1'b0),
        .out_valid(out_valid8), .out_ready(1'b1), .cmp(cmp8), .out_tag(out_tag8)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp;
    } vec_t;

    typedef struct {
        logic       c;
        logic [4:0] t;
    } exp_t;

    vec_t vecs[20];
    exp_t sbq[$];
    logic cur_exp;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            3'd0: return x != y;
            3'd1: return x == y;
            3'd2: return $signed(x) < $signed(y);
            3'd3: return x < y;
            3'd4: return $signed(x) >= 0;
            3'd5: return $signed(x) < 0;
            3'd6: return $signed(x) <= 0;
            default: return $signed(x) > 0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs change at posedge+1, so negedge values are what the next edge will see.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (in_valid && in_ready && !flush)
                sbq.push_back(exp_t'{c: cur_exp, t: tag});
            if (out_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got tag=%0d cmp=%0d exp=none", out_tag, cmp);
                end else begin
                    e = sbq.pop_front();
                    if (cmp !== e.c || out_tag !== e.t) begin
                        failures++;
                        $display("FAIL sb_result got tag=%0d cmp=%0d exp tag=%0d cmp=%0d",
                                 out_tag, cmp, e.t, e.c);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx, cyc;
        logic accepted, prev_stall;
        logic [4:0] held_tag;

        vecs[0]  = '{3'b010, 32'hFFFFFFFF, 32'h00000001, 1'b1};
        vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        vecs[2]  = '{3'b010, 32'h80000000, 32'h7FFFFFFF, 1'b1};
        vecs[3]  = '{3'b010, 32'h7FFFFFFF, 32'h80000000, 1'b0};
        vecs[4]  = '{3'b000, 32'h12345678, 32'h12345678, 1'b0};
        vecs[5]  = '{3'b001, 32'h12345678, 32'h12345678, 1'b1};
        vecs[6]  = '{3'b100, 32'h00000000, 32'hDEADBEEF, 1'b1};
        vecs[7]  = '{3'b100, 32'h00000001, 32'hDEADBEEF, 1'b1};
        vecs[8]  = '{3'b100, 32'h80000000, 32'hDEADBEEF, 1'b0};
        vecs[9]  = '{3'b101, 32'h00000000, 32'hDEADBEEF, 1'b0};
        vecs[10] = '{3'b101, 32'h00000001, 32'hDEADBEEF, 1'b0};
        vecs[11] = '{3'b101, 32'h80000000, 32'hDEADBEEF, 1'b1};
        vecs[12] = '{3'b110, 32'h00000000, 32'hDEADBEEF, 1'b1};
        vecs[13] = '{3'b110, 32'h00000001, 32'hDEADBEEF, 1'b0};
        vecs[14] = '{3'b110, 32'h80000000, 32'hDEADBEEF, 1'b1};
        vecs[15] = '{3'b111, 32'h00000000, 32'hDEADBEEF, 1'b0};
        vecs[16] = '{3'b111, 32'h00000001, 32'hDEADBEEF, 1'b1};
        vecs[17] = '{3'b111, 32'h80000000, 32'hDEADBEEF, 1'b0};
        vecs[18] = '{3'b000, 32'h00000001, 32'h00000000, 1'b1};
        vecs[19] = '{3'b011, 32'h00000000, 32'hFFFFFFFF, 1'b1};

        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0; tag = '0; cur_exp = 1'b0;
        in_valid8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; tag8 = '0;

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cmp", cmp, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid8", out_valid8, 0);
        step();
        reset = 1'b1;

        // Vector table, back-to-back.
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            tag = 5'(i + 1); cur_exp = vecs[i].exp;
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("table_drain", sbq.size(), 0);

        // Exact latency.
        in_valid = 1'b1; op = 3'b001; a = 32'd5; b = 32'd5; tag = 5'd9; cur_exp = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("lat_early", out_valid, 0);
        @(negedge clk);
        chk("lat_exact_valid", out_valid, 1);
        chk("lat_exact_cmp", cmp, 1);
        chk("lat_exact_tag", out_tag, 9);
        step();
        repeat (2) step();

        // Back-pressure: tags 1..6 with a 3-cycle stall mid-stream.
        idx = 1; cyc = 0; prev_stall = 1'b0; held_tag = '0;
        while (idx <= 6 && cyc < 40) begin
            out_ready = !(cyc >= 3 && cyc < 6);
            in_valid = 1'b1; op = 3'b011; a = 32'(idx); b = 32'd3; tag = 5'(idx);
            cur_exp = model(op, a, b);
            #1;
            if (!out_ready && out_valid) begin
                chk("stall_in_ready", in_ready, 0);
                if (prev_stall) chk("stall_hold_tag", out_tag, held_tag);
                held_tag = out_tag;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            accepted = in_ready;
            @(posedge clk); #1;
            if (accepted) idx++;
            cyc++;
        end
        chk("bp_all_accepted", idx, 7);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        chk("bp_drain", sbq.size(), 0);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            tag = 5'($urandom);
            cur_exp = model(op, a, b);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        chk("rand_drain", sbq.size(), 0);

        // Flush with two in flight, stalled output and a live input.
        in_valid = 1'b1; op = 3'b001; a = 32'd1; b = 32'd1; tag = 5'd20; cur_exp = 1'b1;
        step();
        tag = 5'd21;
        step();
        out_ready = 1'b0; flush = 1'b1; tag = 5'd22;
        sbq.delete();
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("flush_no_valid", out_valid, 0);
            step();
        end
        chk("flush_queue", sbq.size(), 0);

        // Async reset while full.
        in_valid = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4; tag = 5'd30; cur_exp = 1'b1;
        step();
        tag = 5'd31;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        reset = 1'b0;
        sbq.delete();
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_cmp", cmp, 0);
        chk("arst_out_tag", out_tag, 0);
        chk("arst_in_ready", in_ready, 1);
        step();
        reset = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_no_spurious", out_valid, 0);
            step();
        end

        // Narrow LAT=1 build.
        for (int i = 0; i < 2; i++) begin
            in_valid8 = 1'b1;
            op8  = (i == 0) ? 3'b011 : 3'b010;
            a8   = (i == 0) ? 8'h01 : 8'h80;
            b8   = (i == 0) ? 8'hFF : 8'h7F;
            tag8 = 3'(i + 5);
            #1;
            chk("w8_in_ready", in_ready8, 1);
            @(posedge clk); #1; in_valid8 = 1'b0;
            @(negedge clk);
            chk("w8_valid", out_valid8, 1);
            chk("w8_cmp", cmp8, 1);
            chk("w8_tag", out_tag8, 32'(i + 5));
            step();
            chk("w8_bubble", out_valid8, 0);
        end

        chk("final_queue", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
